// File: rtl/fft_r2sdf_stage_if.sv
`timescale 1ns/1ps
// fft_r2sdf_stage_if: this bundle carries the sample stream into and out of one R2SDF stage.
// Ports: valid_i/flush_i/data_in_r/data_in_i go upstream->stage; valid_o/sop_o/busy_o/data_out_r/data_out_i go stage->downstream.
// Modports: slave is the stage's view and master is the driver/monitor view. OUT_W is one bit wider than DATA_W to hold butterfly growth.
interface fft_r2sdf_stage_if #(
   parameter int DATA_W = 14,
   parameter int OUT_W  = DATA_W + 1
);
   logic                     valid_i;
   logic                     flush_i;
   logic signed [DATA_W-1:0] data_in_r;
   logic signed [DATA_W-1:0] data_in_i;
   logic                     valid_o;
   logic                     sop_o;
   logic                     busy_o;
   logic signed [OUT_W-1:0]  data_out_r;
   logic signed [OUT_W-1:0]  data_out_i;

   modport slave (
      input  valid_i, flush_i, data_in_r, data_in_i,
      output valid_o, sop_o, busy_o, data_out_r, data_out_i
   );

   modport master (
      output valid_i, flush_i, data_in_r, data_in_i,
      input  valid_o, sop_o, busy_o, data_out_r, data_out_i
   );
endinterface

// File: rtl/fft_r2sdf_stage.sv
`timescale 1ns/1ps
// fft_r2sdf_stage: this module is one radix-2 single-path delay-feedback butterfly stage, with an optional trivial -j rotation.
// Ports: clk and rst_n (async, active low), plus bus (slave modport), which carries the input samples, flush, outputs, sop and busy.
// Latency: a sum leaves L+1 advances after its first operand. With no valid_i and no drain, the stage holds state and drops valid_o.
module fft_r2sdf_stage #(
   parameter int DATA_W = 14,
   parameter int DELAY  = 8,
   parameter int ROT_EN = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   fft_r2sdf_stage_if.slave bus
);
   localparam int OUT_W = DATA_W + 1;
   localparam int CNT_W = $clog2(2 * DELAY);
   localparam logic [CNT_W-1:0] CNT_L   = CNT_W'(DELAY);
   localparam logic [CNT_W-1:0] CNT_LM1 = CNT_W'(DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_LH  = CNT_W'(DELAY / 2);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // In S_PRIMED, the delay line holds the differences of the previous block.
   typedef enum logic {S_EMPTY, S_PRIMED} state_t;
   state_t state, state_nxt;

   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic signed [OUT_W-1:0] dl_r [DELAY];
   logic signed [OUT_W-1:0] dl_i [DELAY];
   logic signed [OUT_W-1:0] x_r, x_i, d_r, d_i;
   logic signed [OUT_W-1:0] push_r, push_i, res_r, res_i;
   logic signed [OUT_W-1:0] out_r_q, out_i_q;
   logic                    valid_q, sop_q;
   logic                    primed, phase_b, adv, at_last_a, rot_slot, emit;

   assign primed    = (state == S_PRIMED);
   assign phase_b   = (cnt >= CNT_L);
   // A drain step only makes sense in phase A, where there are stored differences to push out.
   assign adv       = bus.valid_i | (bus.flush_i & primed & ~phase_b);
   assign at_last_a = (cnt == CNT_LM1);
   assign rot_slot  = (ROT_EN != 0) && (cnt >= CNT_LH);
   // Phase-A outputs of the first block after (re)start would be zeros from the empty line.
   assign emit      = phase_b | primed;

   // While flushing, the input is forced to zero so that the line drains to zeros.
   assign x_r = bus.valid_i ? {bus.data_in_r[DATA_W-1], bus.data_in_r} : '0;
   assign x_i = bus.valid_i ? {bus.data_in_i[DATA_W-1], bus.data_in_i} : '0;
   assign d_r = dl_r[DELAY-1];
   assign d_i = dl_i[DELAY-1];

   // Butterfly datapath. OUT_W holds every sum and difference of two DATA_W words exactly.
   // The negation in the -j slot is safe because a stored difference is never the most negative OUT_W value.
   always_comb begin
      push_r = x_r;
      push_i = x_i;
      res_r  = d_r;
      res_i  = d_i;
      if (phase_b) begin
         res_r  = d_r + x_r;
         res_i  = d_i + x_i;
         push_r = d_r - x_r;
         push_i = d_i - x_i;
      end else if (rot_slot) begin
         res_r = d_i;
         res_i = -d_r;
      end
   end

   // Priming FSM and sample counter. 2L is a power of two, so the counter wraps on its own.
   // When a drain step ends phase A, the stage returns to an idle, empty state at count 0.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (adv) begin
         cnt_nxt = cnt + CNT_ONE;
         if (at_last_a) begin
            if (bus.valid_i) begin
               state_nxt = S_PRIMED;
            end else begin
               state_nxt = S_EMPTY;
               cnt_nxt   = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_EMPTY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Feedback delay line: a plain shift register of L complex entries. The oldest entry is at index DELAY-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DELAY; k++) begin
            dl_r[k] <= '0;
            dl_i[k] <= '0;
         end
      end else if (adv) begin
         dl_r[0] <= push_r;
         dl_i[0] <= push_i;
         for (int k = 1; k < DELAY; k++) begin
            dl_r[k] <= dl_r[k-1];
            dl_i[k] <= dl_i[k-1];
         end
      end
   end

   // Output register. The data is updated only on emitted samples, so it holds through gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         out_r_q <= '0;
         out_i_q <= '0;
      end else begin
         valid_q <= adv & emit;
         sop_q   <= adv & (cnt == CNT_L);
         if (adv && emit) begin
            out_r_q <= res_r;
            out_i_q <= res_i;
         end
      end
   end

   assign bus.valid_o    = valid_q;
   assign bus.sop_o      = sop_q;
   assign bus.busy_o     = primed;
   assign bus.data_out_r = out_r_q;
   assign bus.data_out_i = out_i_q;
endmodule
